// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decode/extend, then a main + skid entry with a registered in_ready.
// Optional macro IMM_GEN_ZICSR_EN: when defined, extop 111 decodes the CSR zimm field instead of reporting err.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       extop,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] tag_out,
  output logic             err
);

  // Handshake: a word transfers on any edge where valid and ready are both high;
  // the producer holds its payload stable until then, and ready never depends on valid.

  localparam int SW = (XLEN == 32) ? 5 : 6;

  localparam logic [2:0] EXT_S     = 3'b001;
  localparam logic [2:0] EXT_I     = 3'b010;
  localparam logic [2:0] EXT_SHAMT = 3'b011;
  localparam logic [2:0] EXT_B     = 3'b100;
  localparam logic [2:0] EXT_U     = 3'b101;
  localparam logic [2:0] EXT_J     = 3'b110;

  logic [31:0]     field;
  logic            field_sx;
  logic [XLEN-1:0] ext_imm;
  logic            ext_err;
  logic            unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    field    = '0;
    field_sx = 1'b0;
    ext_err  = 1'b0;
    case (extop)
      EXT_I: begin
        field    = {{20{instr[31]}}, instr[31:20]};
        field_sx = 1'b1;
      end
      EXT_S: begin
        field    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        field_sx = 1'b1;
      end
      EXT_B: begin
        field    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        field_sx = 1'b1;
      end
      EXT_U: begin
        field    = {instr[31:12], 12'h000};
        field_sx = 1'b1;
      end
      EXT_J: begin
        field    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        field_sx = 1'b1;
      end
      EXT_SHAMT: begin
        field[SW-1:0] = instr[20 +: SW];
      end
`ifdef IMM_GEN_ZICSR_EN
      3'b111: begin
        field[4:0] = instr[19:15];
      end
`endif
      default: begin
        ext_err = 1'b1;
      end
    endcase
  end

  // Fill the upper XLEN bits from bit 31 for signed types, zero otherwise.
  always_comb begin
    ext_imm        = {XLEN{field_sx & field[31]}};
    ext_imm[31:0]  = field;
  end

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_err_q, skid_err_d;
  logic             accept;
  logic             drain;

  assign accept = in_valid & ~skid_valid_q;
  assign drain  = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    imm_d        = imm_q;
    tag_d        = tag_q;
    err_d        = err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      // Payload registers keep their value; only the valid bits are killed.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        imm_d        = skid_imm_q;
        tag_d        = skid_tag_q;
        err_d        = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        imm_d       = ext_imm;
        tag_d       = tag_in;
        err_d       = ext_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = ext_imm;
      skid_tag_d   = tag_in;
      skid_err_d   = ext_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      imm_q        <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      imm_q        <= imm_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign imm       = imm_q;
  assign tag_out   = tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe (XLEN=32): directed spec vectors, stall/skid, flush, async reset, random traffic.
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 32;
  localparam int W     = 1 + XLEN + TAG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       extop;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [TAG_W-1:0] tag_out;
  logic             err;

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .extop(extop), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .tag_out(tag_out), .err(err)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check_eq(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // Reference decode written straight from the encoding tables.
  function automatic logic [32:0] model(input logic [31:0] i, input logic [2:0] op);
    logic [31:0] v;
    logic e;
    v = '0;
    e = 1'b0;
    case (op)
      3'b010: v = {{20{i[31]}}, i[31:20]};
      3'b001: v = {{20{i[31]}}, i[31:25], i[11:7]};
      3'b100: v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b101: v = {i[31:12], 12'h000};
      3'b110: v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'b011: v = {27'd0, i[24:20]};
`ifdef IMM_GEN_ZICSR_EN
      3'b111: v = {27'd0, i[19:15]};
`endif
      default: e = 1'b1;
    endcase
    return {e, v};
  endfunction

  // Driver tasks: all start and end at posedge + 1.
  task automatic send(input logic [31:0] ins, input logic [2:0] op, input logic [31:0] tg,
                      input logic [32:0] e);
    int guard;
    guard = 0;
    instr = ins; extop = op; tag_in = tg; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("send_timeout", W'(in_ready), W'(1));
    else exp_q.push_back({e, tg});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("drain_done", W'(exp_q.size()), W'(0));
  endtask

  // Scoreboard: pop and compare on every drain.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {err, imm, tag_out}, W'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", {err, imm, tag_out}, e);
      end
    end
  end

  initial begin
    int t0;
    logic [31:0] ri;
    logic [2:0]  rop;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; extop = '0; tag_in = '0;
    out_ready = 1'b0;
    #3;
    check_eq("rst_out_valid", W'(out_valid), W'(0));
    check_eq("rst_in_ready", W'(in_ready), W'(1));
    check_eq("rst_payload", {err, imm, tag_out}, W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("post_rst_in_ready", W'(in_ready), W'(1));

    // Directed vectors with their documented results.
    rdy_mode = 0;
    send(32'hFFF00093, 3'b010, 32'h1000, {1'b0, 32'hFFFFFFFF});
    check_eq("latency_1cycle", W'(out_valid), W'(1));
    send(32'hFE20AE23, 3'b001, 32'h1004, {1'b0, 32'hFFFFFFFC});
    send(32'hFE000CE3, 3'b100, 32'h1008, {1'b0, 32'hFFFFFFF8});
    send(32'h123450B7, 3'b101, 32'h100C, {1'b0, 32'h12345000});
    send(32'h001000EF, 3'b110, 32'h1010, {1'b0, 32'h00000800});
    send(32'h01F0D093, 3'b011, 32'h1014, {1'b0, 32'h0000001F});
    send(32'hFFF00093, 3'b000, 32'h1018, {1'b1, 32'h00000000});
`ifdef IMM_GEN_ZICSR_EN
    send(32'h3402D073, 3'b111, 32'h101C, {1'b0, 32'h00000005});
`else
    send(32'h3402D073, 3'b111, 32'h101C, {1'b1, 32'h00000000});
`endif
    wait_empty();

    // Stall: out_ready low for three cycles with in_valid held high.
    rdy_mode = 2;
    instr = 32'h00500093; extop = 3'b010; tag_in = 32'hA0; in_valid = 1'b1;
    check_eq("stall_rdy_a", W'(in_ready), W'(1));
    exp_q.push_back({model(32'h00500093, 3'b010), 32'hA0});
    @(posedge clk); #1;
    check_eq("stall_out_valid", W'(out_valid), W'(1));
    check_eq("stall_rdy_b", W'(in_ready), W'(1));
    instr = 32'hFFB00113; tag_in = 32'hA1;
    exp_q.push_back({model(32'hFFB00113, 3'b010), 32'hA1});
    @(posedge clk); #1;
    check_eq("stall_rdy_fall", W'(in_ready), W'(0));
    instr = 32'h7FF00193; tag_in = 32'hA2;
    @(posedge clk); #1;
    check_eq("stall_rdy_low", W'(in_ready), W'(0));
    check_eq("stall_hold", {err, imm, tag_out}, {model(32'h00500093, 3'b010), 32'hA0});
    in_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    check_eq("stall_rdy_rise", W'(in_ready), W'(1));
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      ri = $urandom;
      send(ri, 3'b110, 32'hB0 + 32'(k), model(ri, 3'b110));
    end
    check_eq("throughput", W'(cyc - t0), W'(8));
    wait_empty();

    // Flush with both entries full and a word offered.
    rdy_mode = 2;
    send(32'h12300093, 3'b010, 32'hC0, model(32'h12300093, 3'b010));
    send(32'h45600093, 3'b010, 32'hC1, model(32'h45600093, 3'b010));
    instr = 32'h78900093; extop = 3'b010; tag_in = 32'hC2; in_valid = 1'b1; flush = 1'b1;
    check_eq("flush_full_rdy", W'(in_ready), W'(0));
    @(posedge clk); #1;
    exp_q.delete();
    check_eq("flush_out_valid", W'(out_valid), W'(0));
    check_eq("flush_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    check_eq("flush_beats_accept", W'(out_valid), W'(0));
    flush = 1'b0; in_valid = 1'b0;
    rdy_mode = 0;
    send(32'hABC00093, 3'b010, 32'hC3, model(32'hABC00093, 3'b010));
    wait_empty();

    // Asynchronous reset mid-stream.
    rdy_mode = 2;
    send(32'h80000037, 3'b101, 32'hD0, model(32'h80000037, 3'b101));
    check_eq("pre_rst_valid", W'(out_valid), W'(1));
    #3 rst = 1'b1;
    #1;
    exp_q.delete();
    check_eq("async_rst_valid", W'(out_valid), W'(0));
    check_eq("async_rst_payload", {err, imm, tag_out}, W'(0));
    check_eq("async_rst_in_ready", W'(in_ready), W'(1));
    rdy_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("no_stale_after_rst", W'(out_valid), W'(0));
    end
    send(32'h00000013, 3'b011, 32'hD1, model(32'h00000013, 3'b011));
    wait_empty();

    // Random traffic with random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 200; k++) begin
      ri  = $urandom;
      rop = 3'($urandom_range(0, 7));
      send(ri, rop, $urandom, model(ri, rop));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 0;
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
